// File: rtl/sid_vca_pkg.sv
// sid_pkg: shared widths, waveform midpoint and FSM state encoding for the sid_vca voice amplitude stage.
package sid_pkg;
    localparam int WAVE_W = 12;
    localparam int ENV_W = 8;
    localparam int OUT_W = 16;
    localparam int ACC_W = WAVE_W + ENV_W;
    localparam logic [WAVE_W-1:0] WAVE_MID = 12'h800;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/sid_vca_if.sv
// sid_vca_if: sample strobe, operands and scaled-sample outputs of the voice amplitude stage.
interface sid_vca_if;
    import sid_pkg::*;
    logic clkEn;
    logic [WAVE_W-1:0] iWave;
    logic [ENV_W-1:0] iEnv;
    logic [OUT_W-1:0] oOut;
    logic oValid;
    logic oBusy;
    modport master(output clkEn, iWave, iEnv, input oOut, oValid, oBusy);
    modport slave(input clkEn, iWave, iEnv, output oOut, oValid, oBusy);
endinterface

// File: rtl/sid_vca_mul.sv
// sid_vca_mul: iterative shift-add signed-by-unsigned multiplier, one multiplier bit per step.
module sid_vca_mul #(
    parameter int ENV_W = 8,
    parameter int ACC_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_step,
    input  logic signed [ACC_W-1:0] i_mcand,
    input  logic [ENV_W-1:0] i_mplier,
    output logic o_last,
    output logic signed [ACC_W-1:0] o_acc
);
    localparam int CNT_W = $clog2(ENV_W);
    logic signed [ACC_W-1:0] r_mcand;
    logic signed [ACC_W-1:0] r_acc;
    logic [ENV_W-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_acc <= '0;
            r_mplier <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_mcand <= i_mcand;
            r_acc <= '0;
            r_mplier <= i_mplier;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= r_mplier[0] ? r_acc + r_mcand : r_acc;
            r_mcand <= r_mcand <<< 1;
            r_mplier <= r_mplier >> 1;
            r_cnt <= r_cnt + 1'b1;
        end
    end
    assign o_last = r_cnt == CNT_W'(ENV_W - 1);
    assign o_acc = r_acc;
endmodule

// File: rtl/sid_vca.sv
// sid_vca: scales a voice waveform sample by the envelope once per clkEn, 10 clk latency.
// Define SID_VCA_ROUND_EN to round half up instead of truncating toward -inf.
module sid_vca
    import sid_pkg::*;
(
    input logic clk,
    input logic rst,
    sid_vca_if.slave bus
);
    state_t r_state;
    logic [OUT_W-1:0] r_out;
    logic r_valid;
    logic w_start;
    logic w_last;
    logic [WAVE_W-1:0] w_off;
    logic signed [ACC_W-1:0] w_mcand;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_res;
    // Subtracting the midpoint is a top-bit flip, giving a two's complement offset sample
    assign w_off = bus.iWave ^ WAVE_MID;
    assign w_mcand = {{ENV_W{w_off[WAVE_W-1]}}, w_off};
    assign w_start = r_state == IDLE && bus.clkEn;
`ifdef SID_VCA_ROUND_EN
    assign w_res = w_acc + ACC_W'(1 << (ACC_W - OUT_W - 1));
`else
    assign w_res = w_acc;
`endif
    sid_vca_mul #(.ENV_W(ENV_W), .ACC_W(ACC_W)) u_mul (
        .clk(clk),
        .rst(rst),
        .i_start(w_start),
        .i_step(r_state == MUL),
        .i_mcand(w_mcand),
        .i_mplier(bus.iEnv),
        .o_last(w_last),
        .o_acc(w_acc)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_out <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: r_state <= bus.clkEn ? MUL : IDLE;
                MUL: r_state <= w_last ? DONE : MUL;
                DONE: begin
                    r_out <= w_res[ACC_W-1 -: OUT_W];
                    r_valid <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.oOut = r_out;
    assign bus.oValid = r_valid;
    assign bus.oBusy = r_state != IDLE;
endmodule

// File: tb/tb_sid_vca.sv
// tb_sid_vca: randomized and directed scoreboard bench for sid_vca against an arithmetic reference model.
module tb_sid_vca;
    typedef struct {
        logic [15:0] val;
        int t;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int last_a = -100;
    bit mon_on = 1'b0;
    logic [15:0] model_out = '0;
    exp_t q[$];
    sid_vca_if bus();
    sid_vca dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
        end
    endtask
    // Product of the centred sample and the envelope, scaled by 2^-4 with floor (or half-up rounding)
    function automatic logic [15:0] model(input logic [11:0] w, input logic [7:0] e);
        int p;
        p = (int'(w) - 2048) * int'(e);
`ifdef SID_VCA_ROUND_EN
        p = p + 8;
`endif
        return 16'(p >>> 4);
    endfunction
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    // An operation latched at edge a is busy through a+8 and reports at a+9; the next strobe is taken from a+10
    task automatic issue(input logic [11:0] w, input logic [7:0] e);
        bus.iWave = w;
        bus.iEnv = e;
        bus.clkEn = 1'b1;
        @(posedge clk);
        #1;
        bus.clkEn = 1'b0;
        bus.iWave = 12'($urandom);
        bus.iEnv = 8'($urandom);
        if (cyc >= last_a + 10) begin
            q.push_back('{val: model(w, e), t: cyc + 9});
            last_a = cyc;
        end
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.clkEn = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        last_a = -100;
        model_out = '0;
        rst = 1'b0;
    endtask
    always @(negedge clk) begin
        if (mon_on) begin
            if (q.size() > 0 && cyc > q[0].t) begin
                chk("missed_valid", 32'(cyc), 32'(q[0].t));
                void'(q.pop_front());
            end
            if (bus.oValid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 32'(bus.oValid), 32'd0);
                end else begin
                    chk("valid_cycle", 32'(cyc), 32'(q[0].t));
                    model_out = q[0].val;
                    void'(q.pop_front());
                end
            end
            chk("out", 32'(bus.oOut), 32'(model_out));
            chk("busy", 32'(bus.oBusy), 32'(cyc >= last_a && cyc <= last_a + 8));
        end
    end
    initial begin
        bus.clkEn = 1'b0;
        bus.iWave = '0;
        bus.iEnv = '0;
        do_reset();
        do_reset();
        mon_on = 1'b1;
        idle(2);
        issue(12'hFFF, 8'hFF);
        idle(12);
        issue(12'h000, 8'hFF);
        idle(12);
        issue(12'h800, 8'hFF);
        idle(12);
        issue(12'hABC, 8'h00);
        idle(12);
        issue(12'h123, 8'h9A);
        idle(2);
        issue(12'hFFF, 8'hFF);
        idle(6);
        issue(12'h000, 8'h81);
        idle(12);
        issue(12'hFFF, 8'hFF);
        idle(4);
        do_reset();
        idle(3);
        issue(12'h3C7, 8'h5E);
        idle(12);
        issue(12'h801, 8'h08);
        idle(12);
        for (int i = 0; i < 60; i++) begin
            issue(12'($urandom), 8'($urandom));
            idle($urandom_range(0, 14));
        end
        idle(15);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
